// File: rtl/comparator_arbiter_if.sv
// ---------------------------------------------------------------------------
// comparator_arbiter_if
// Purpose : groups the request and response signals of comparator_arbiter.
// Signals :
//   req_valid[3:0]        per-requester request valid
//   req_a / req_b         packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready[3:0]        one-hot grant/accept strobe
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                owner of the current response
//   rsp_gt/rsp_lt/rsp_eq  unsigned compare result, one-hot
//   busy                  block is not idle
//   cmp_count             completed response handshakes (wraps)
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface comparator_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_a;
  logic [4*DATA_W-1:0] req_b;
  logic [3:0]          req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic                rsp_gt;
  logic                rsp_lt;
  logic                rsp_eq;
  logic                busy;
  logic [15:0]         cmp_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy, cmp_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy, cmp_count
  );
endinterface

// File: rtl/comparator_arbiter.sv
// ---------------------------------------------------------------------------
// comparator_arbiter
// Purpose : shares one unsigned DATA_W comparator among four requesters using
//           round-robin arbitration and a three-state sequencer.
// Ports   :
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    comparator_arbiter_if.slave (request/response handshakes, status)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; grants one in the same cycle it is seen
// CMP    | captured operands are compared, result registered
// RESP   | result presented until rsp_ready accepts it
// ---------------------------------------------------------------------------
module comparator_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comparator_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_rr_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [1:0]          r_id;
  logic                r_gt;
  logic                r_lt;
  logic                r_eq;
  logic [15:0]         r_cmp_count;

  logic                w_grant_any;
  logic [1:0]          w_grant_id;
  logic [1:0]          w_scan;
  logic                w_grant;
  logic                w_rsp_hs;
  logic [3:0]          w_req_ready;

  // Round-robin search: first set valid bit at or after r_rr_ptr, modulo 4.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = 2'd0;
    w_scan      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_scan = r_rr_ptr + 2'(k);
      if (!w_grant_any && bus.req_valid[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_scan;
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_grant_any;
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready;

  // Gated by rst_n so the strobe drops immediately while reset is held,
  // even if requesters keep their valids asserted.
  always_comb begin
    w_req_ready = 4'b0000;
    if (rst_n && w_grant) begin
      w_req_ready = 4'b0001 << w_grant_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 2'd0;
    end else if (w_grant) begin
      r_rr_ptr <= w_grant_id + 2'd1;
      r_a      <= bus.req_a[w_grant_id*DATA_W +: DATA_W];
      r_b      <= bus.req_b[w_grant_id*DATA_W +: DATA_W];
      r_id     <= w_grant_id;
    end
  end

  // Result flags only change in CMP, so they stay stable through RESP
  // regardless of how long the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt <= 1'b0;
      r_lt <= 1'b0;
      r_eq <= 1'b0;
    end else if (r_state == S_CMP) begin
      r_gt <= (r_a > r_b);
      r_lt <= (r_a < r_b);
      r_eq <= (r_a == r_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_count <= 16'd0;
    end else if (w_rsp_hs) begin
      r_cmp_count <= r_cmp_count + 16'd1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_gt    = r_gt;
  assign bus.rsp_lt    = r_lt;
  assign bus.rsp_eq    = r_eq;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.cmp_count = r_cmp_count;

endmodule

// File: tb/tb_comparator_arbiter.sv
// ---------------------------------------------------------------------------
// tb_comparator_arbiter
// Purpose : self-checking bench for comparator_arbiter. A transaction-level
//           reference (pending request, its age in cycles, pointer, count)
//           predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_comparator_arbiter;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comparator_arbiter_if #(.DATA_W(DATA_W)) bus();

  comparator_arbiter #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference state
  int          m_ptr = 0;
  int          m_busy = 0;
  int          m_age = 0;
  int          m_id = 0;
  int          m_count = 0;
  logic [7:0]  m_a = 8'h00;
  logic [7:0]  m_b = 8'h00;
  int          cyc = 0;
  int          g_ids[$];
  int          g_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_busy = 0;
    m_age = 0;
    m_count = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
    chk({tag, "_gt"},        32'(bus.rsp_gt), 0);
    chk({tag, "_lt"},        32'(bus.rsp_lt), 0);
    chk({tag, "_eq"},        32'(bus.rsp_eq), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_count"},     32'(bus.cmp_count), 0);
  endtask

  // One clock cycle: drive, check at negedge, advance reference on posedge.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy);
    logic [3:0] exp_rdy;
    int gid;
    int idx;
    int rv;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rdy;
    @(negedge clk);
    gid = -1;
    exp_rdy = 4'b0000;
    if (m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (gid < 0 && v[idx]) gid = idx;
      end
    end
    if (gid >= 0) exp_rdy = 4'b0001 << gid;
    rv = (m_busy != 0 && m_age >= 2) ? 1 : 0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy",      32'(bus.busy), 32'(m_busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
    chk("cmp_count", 32'(bus.cmp_count), 32'(m_count));
    if (rv != 0) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_gt", 32'(bus.rsp_gt), (m_a > m_b) ? 32'd1 : 32'd0);
      chk("rsp_lt", 32'(bus.rsp_lt), (m_a < m_b) ? 32'd1 : 32'd0);
      chk("rsp_eq", 32'(bus.rsp_eq), (m_a == m_b) ? 32'd1 : 32'd0);
      chk("onehot", 32'(bus.rsp_gt) + 32'(bus.rsp_lt) + 32'(bus.rsp_eq), 32'd1);
    end
    @(posedge clk);
    if (gid >= 0) begin
      g_ids.push_back(gid);
      g_cyc.push_back(cyc);
      m_busy = 1;
      m_age  = 1;
      m_id   = gid;
      m_a    = a[gid*8 +: 8];
      m_b    = b[gid*8 +: 8];
      m_ptr  = (gid + 1) % 4;
    end else if (m_busy != 0) begin
      if (m_age >= 2 && rdy) begin
        m_busy  = 0;
        m_count = (m_count + 1) % 65536;
      end else begin
        m_age++;
      end
    end
    cyc++;
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear before next edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_one(input int who, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] pa;
    logic [31:0] pb;
    pa = '0;
    pb = '0;
    pa[who*8 +: 8] = a;
    pb[who*8 +: 8] = b;
    step(4'b0001 << who, pa, pb, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, '0, '0, 1'b1);
  endtask

  initial begin
    int c0;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request, requester 2, 0x99 vs 0x66
    g_ids.delete();
    g_cyc.delete();
    c0 = cyc;
    step(4'b0100, 32'h0099_0000, 32'h0066_0000, 1'b1);
    chk("single_grant_id", (g_ids.size() > 0) ? 32'(g_ids[0]) : 32'hFFFF_FFFF, 32'd2);
    step(4'b0000, '0, '0, 1'b1);
    @(negedge clk);
    chk("single_lat_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_lat_gt", 32'(bus.rsp_gt), 32'd1);
    @(posedge clk);
    #1;
    // the manual wait above consumed the RESP handshake edge
    m_busy = 0;
    m_count = (m_count + 1) % 65536;
    cyc++;
    step(4'b0000, '0, '0, 1'b1);
    chk("single_count", 32'(bus.cmp_count), 32'd1);

    // compare corner values
    run_one(0, 8'h00, 8'h00);
    run_one(1, 8'h33, 8'h44);
    run_one(3, 8'hFF, 8'hFF);
    run_one(2, 8'h00, 8'hFF);

    // round-robin with all requesters held, starting from pointer 0
    async_reset("rst_rr");
    g_ids.delete();
    g_cyc.delete();
    for (int i = 0; i < 13; i++) step(4'b1111, 32'h1122_3344, 32'h4433_2211, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", (g_ids.size() > i) ? 32'(g_ids[i]) : 32'hFFFF_FFFF, 32'(i % 4));
      if (i > 0)
        chk("rr_spacing", (g_cyc.size() > i) ? 32'(g_cyc[i] - g_cyc[i-1]) : 32'hFFFF_FFFF, 32'd3);
    end
    step(4'b0000, '0, '0, 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    step(4'b0000, '0, '0, 1'b1);

    // backpressure: grant, CMP, then RESP stalled for 5+ cycles
    c0 = m_count;
    step(4'b0010, 32'h0000_7000, 32'h0000_7100, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0000, '0, '0, 1'b0);
    chk("bp_count_held", 32'(bus.cmp_count), 32'(c0));
    step(4'b0000, '0, '0, 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    chk("bp_count_inc", 32'(bus.cmp_count), 32'((c0 + 1) % 65536));

    // reset during CMP of the requester-3 transaction, 4'b1010 held
    async_reset("rst_pre");
    g_ids.delete();
    for (int i = 0; i < 4; i++) step(4'b1010, 32'h5500_6600, 32'h5500_6700, 1'b1);
    chk("midop_second_grant", (g_ids.size() > 1) ? 32'(g_ids[1]) : 32'hFFFF_FFFF, 32'd3);
    async_reset("rst_mid");
    g_ids.delete();
    step(4'b1010, 32'h5500_6600, 32'h5500_6700, 1'b1);
    chk("midop_first_grant", (g_ids.size() > 0) ? 32'(g_ids[0]) : 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 3; i++) step(4'b0000, '0, '0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  4  per-requester request valid; bit i belongs to requester i.
REQ-005 req_a  input  4*DATA_W  operand A; requester i uses bits [i*DATA_W +: DATA_W].
REQ-006 req_b  input  4*DATA_W  operand B; same packing as req_a.
REQ-007 req_ready  output  4  one-hot grant/accept strobe, combinational.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  downstream accepts result.
REQ-010 rsp_id  output  2  index of the requester that owns the result.
REQ-011 rsp_gt / rsp_lt / rsp_eq  output  1 each  A>B, A<B, A==B, unsigned compare.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 cmp_count  output  16  count of completed response handshakes.

Function
REQ-014 The block SHALL share one unsigned DATA_W comparator among 4 requesters under a 3-state FSM: IDLE, CMP, RESP.
REQ-015 IDLE: if any req_valid bit is set, grant the first set bit at or after rr_ptr (search rr_ptr, rr_ptr+1, ... mod 4), assert that req_ready bit in the same cycle, capture its A, B and index, set rr_ptr <= grant+1 mod 4, and go to CMP.
REQ-016 IDLE with no req_valid bit set: stay in IDLE, req_ready = 0, rr_ptr unchanged.
REQ-017 req_ready SHALL be 0 in CMP and RESP, and at most one bit SHALL ever be high.
REQ-018 A request counts as accepted only when req_valid[i] and req_ready[i] are both high at a clock edge; a valid dropped before grant is ignored.
REQ-019 CMP: register gt, lt and eq from the captured operands, with exactly one of the three set, then go to RESP unconditionally.
REQ-020 RESP: rsp_valid = 1 and rsp_id = captured index; on rsp_valid && rsp_ready, go to IDLE and increment cmp_count.
REQ-021 No new grant SHALL occur in the handshake cycle; grant-to-grant spacing is at least 3 cycles.
REQ-022 Latency: grant at cycle T gives rsp_valid high from cycle T+2.
REQ-023 rsp_id, rsp_gt, rsp_lt and rsp_eq SHALL hold stable while rsp_valid && !rsp_ready.
REQ-024 rsp_valid SHALL be 0 in IDLE and CMP.
REQ-025 cmp_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-026 A requester holding req_valid continuously SHALL be granted within 4 grants (starvation-free).

Reset
REQ-027 rst_n low SHALL immediately set: state IDLE; rr_ptr 0; captured operands and index 0; rsp_valid, rsp_gt, rsp_lt, rsp_eq 0; rsp_id 0; busy 0; cmp_count 0; req_ready 0.
REQ-028 Reset asserted during CMP or RESP SHALL discard the in-flight transaction with no response issued.
REQ-029 After rst_n deasserts, the first grant SHALL follow REQ-015 starting from rr_ptr = 0.

Verification
REQ-030 Reset: rst_n = 0 mid-simulation, asynchronous to clk -> all outputs 0 before the next clk edge.
REQ-031 Single request: req_valid = 4'b0100, A2 = 0x99, B2 = 0x66, rsp_ready = 1 -> req_ready = 4'b0100 at cycle T; rsp_valid at T+2 with rsp_id = 2, gt = 1, lt = 0, eq = 0; cmp_count = 1.
REQ-032 Compare values: 0x00/0x00 -> eq; 0x33/0x44 -> lt; 0xFF/0xFF -> eq; each result one-hot.
REQ-033 Round-robin: req_valid = 4'b1111 held, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, with grants 3 cycles apart.
REQ-034 Backpressure: rsp_ready = 0 for 5 cycles during RESP -> rsp_valid and payload stable; req_ready = 0; busy = 1; cmp_count unchanged; on release, cmp_count increments once.
REQ-035 Reset mid-op: rst_n low during CMP of the requester-3 transaction, with req_valid = 4'b1010 held -> no response issued; after release, first grant goes to requester 1.
